lut_mult_pipe: RTL and testbench

//  Parametrised WIDTH x WIDTH multiplier built from 2x2-bit table-lookup partial products.

---
 rtl/lut_mult_pkg.sv | 23 ++
 rtl/lut_mult_pipe_lut2x2.sv | 12 +
 rtl/lut_mult_pipe.sv | 109 ++++++++++
 tb/tb_lut_mult_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_mult_pkg.sv
// Shared constants and the 2x2-bit product table behind the lookup multiplier.
package lut_mult_pkg;

  localparam int LUT_DIGIT_W      = 2;
  localparam int LUT_MULT_LATENCY = 3;

  // {a,b} -> a*b, every 2-bit digit pair
  function automatic logic [2*LUT_DIGIT_W-1:0] lut2x2(input logic [LUT_DIGIT_W-1:0] a,
                                                      input logic [LUT_DIGIT_W-1:0] b);
    logic [2*LUT_DIGIT_W-1:0] p;
    case ({a, b})
      4'h5:       p = 4'd1;
      4'h6, 4'h9: p = 4'd2;
      4'h7, 4'hD: p = 4'd3;
      4'hA:       p = 4'd4;
      4'hB, 4'hE: p = 4'd6;
      4'hF:       p = 4'd9;
      default:    p = 4'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lut_mult_pipe_lut2x2.sv
// One combinational 2x2-bit partial-product lookup.
module lut2x2_mult
  import lut_mult_pkg::*;
(
  input  logic [LUT_DIGIT_W-1:0]   a,
  input  logic [LUT_DIGIT_W-1:0]   b,
  output logic [2*LUT_DIGIT_W-1:0] p
);

  assign p = lut2x2(a, b);

endmodule

// File: rtl/lut_mult_pipe.sv
// WIDTH x WIDTH signed/unsigned multiplier: operand magnitudes, 2x2 table lookups,
// shifted sum. Three stages that advance together under a single adv stall.
module lut_mult_pipe
  import lut_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int D      = WIDTH / LUT_DIGIT_W;
  localparam int NPP    = D * D;
  localparam int PPW    = 2 * LUT_DIGIT_W;
  localparam int OW     = 2 * WIDTH;
  localparam int STAGES = LUT_MULT_LATENCY;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("lut_mult_pipe: WIDTH must be even and >= 4");
  end

  typedef struct packed {
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg;
  } s1_t;

  typedef struct packed {
    logic [NPP-1:0][PPW-1:0] pp;
    logic                    neg;
  } s2_t;

  logic                    adv, accept;
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:1]         vld_pipe_d, vld_pipe_q;
  s1_t                     s1_d, s1_q;
  s2_t                     s2_d, s2_q;
  logic [OW-1:0]           out_d, out_q, sum;
  logic [NPP-1:0][PPW-1:0] pp;

  assign vld_pipe  = {vld_pipe_q, accept};
  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !reset;
  assign accept    = in_valid && in_ready;
  assign out       = out_q;

  // pp[i*D+j] = digit i of |a| times digit j of |b|
  for (genvar i = 0; i < D; i++) begin : g_row
    for (genvar j = 0; j < D; j++) begin : g_col
      lut2x2_mult u_lut (
        .a (s1_q.mag_a[i*LUT_DIGIT_W +: LUT_DIGIT_W]),
        .b (s1_q.mag_b[j*LUT_DIGIT_W +: LUT_DIGIT_W]),
        .p (pp[i*D+j])
      );
    end
  end

  always_comb begin
    vld_pipe_d = adv ? vld_pipe[STAGES-1:0] : vld_pipe_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    out_d = out_q;
    sum   = '0;

    // Most negative value negates to itself, which is the right unsigned magnitude.
    if (accept) begin
      s1_d.mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
      s1_d.mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;
      s1_d.neg   = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    if (adv && vld_pipe[1]) begin
      s2_d.pp  = pp;
      s2_d.neg = s1_q.neg;
    end

    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        sum = sum + (OW'(s2_q.pp[i*D+j]) << (LUT_DIGIT_W * (i + j)));
      end
    end

    if (adv && vld_pipe[2]) out_d = s2_q.neg ? -sum : sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      out_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_lut_mult_pipe.sv
// Scoreboard bench: WIDTH=8 directed/random traffic plus WIDTH=4 exhaustive and WIDTH=16 random.
module tb_lut_mult_pipe;

  logic        clk, reset, in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] out;

  int n_chk = 0;
  int n_fail = 0;
  longint unsigned q[$];
  int run = 0, max_run = 0;
  bit hold_v = 0;
  logic [15:0] hold_out;

  lut_mult_pipe #(.WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Plain integer product of the operands' interpreted values, truncated to 2*w bits.
  function automatic longint unsigned ref_mul(int w, longint unsigned x, longint unsigned y, bit s);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    return longint'(sx * sy) & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic send(logic [7:0] ta, logic [7:0] tb, logic ts);
    bit acc = 0;
    a = ta; b = tb; signed_mode = ts; in_valid = 1;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk);
    end
    if (!acc) check("send accept timeout", 0, 1);
    else q.push_back(ref_mul(8, ta, tb, ts));
    #1;
  endtask

  task automatic drain(string nm);
    int c = 0;
    while ((q.size() != 0 || out_valid) && c < 100) begin @(posedge clk); #1; c++; end
    check(nm, q.size(), 0);
  endtask

  task automatic latency_test(logic [7:0] ta, logic [7:0] tb, logic ts, string nm);
    int cyc = 1;
    send(ta, tb, ts);
    in_valid = 0;
    while (!out_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    check(nm, cyc, 3);
  endtask

  // Monitor: output transfers are popped against the scoreboard; stalls must hold.
  initial forever begin
    @(negedge clk);
    if (hold_v) begin
      check("stall out_valid held", out_valid, 1);
      check("stall out held", out, hold_out);
    end
    if (!reset && out_valid && !out_ready) check("stall in_ready low", in_ready, 0);
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) check("w8 unexpected output", 1, 0);
      else check("w8 product", out, q.pop_front());
      run++;
    end else run = 0;
    if (run > max_run) max_run = run;
    hold_v   = !reset && out_valid && !out_ready;
    hold_out = out;
  end

  // WIDTH=4 exhaustive and WIDTH=16 random, each on its own reset with random back-pressure.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sub
    localparam int W = (gi == 0) ? 4 : 16;
    localparam int N = (gi == 0) ? 512 : 300;
    logic           rst, iv, ir, ov, ordy, sm;
    logic [W-1:0]   sa, sb;
    logic [2*W-1:0] o;
    bit             done = 0;
    longint unsigned sq[$];

    lut_mult_pipe #(.WIDTH(W)) u_dut (
      .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir),
      .a(sa), .b(sb), .signed_mode(sm),
      .out_valid(ov), .out_ready(ordy), .out(o)
    );

    initial begin
      logic [W-1:0] ta, tb;
      logic ts;
      bit acc;
      rst = 1; iv = 0; ordy = 1; sa = '0; sb = '0; sm = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      for (int k = 0; k < N; ) begin
        if (W == 4) begin
          ta = W'(k); tb = W'(k >> 4); ts = k[8];
        end else if (k == 0) begin
          ta = '1; tb = '1; ts = 0;
        end else if (k == 1) begin
          ta = {1'b1, {(W-1){1'b0}}}; tb = ta; ts = 1;
        end else if (k == 2) begin
          ta = '0; tb = {1'b1, {(W-1){1'b0}}}; ts = 1;
        end else begin
          ta = W'($urandom); tb = W'($urandom); ts = 1'($urandom);
        end
        sa = ta; sb = tb; sm = ts;
        iv   = ($urandom % 5) != 0;
        ordy = ($urandom % 4) != 0;
        @(negedge clk); acc = iv && ir;
        @(posedge clk); #1;
        if (acc) begin sq.push_back(ref_mul(W, ta, tb, ts)); k++; end
      end
      iv = 0; ordy = 1;
      for (int c = 0; c < 200 && sq.size() != 0; c++) @(posedge clk);
      done = 1;
    end

    initial forever begin
      @(negedge clk);
      if (!rst && ov && ordy) begin
        if (sq.size() == 0) check($sformatf("w%0d unexpected output", W), 1, 0);
        else check($sformatf("w%0d product", W), o, sq.pop_front());
      end
    end
  end

  initial begin
    int c;
    reset = 1; in_valid = 0; out_ready = 1; a = 0; b = 0; signed_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out", out, 0);
    check("reset in_ready", in_ready, 0);
    @(posedge clk); #1 reset = 0;

    // Latency and the all-ones unsigned product
    latency_test(8'hFF, 8'hFF, 0, "unsigned latency");
    check("unsigned FFxFF", out, 16'hFE01);
    drain("drain t1");

    send(8'h80, 8'h80, 1);
    send(8'hFF, 8'h7F, 1);
    send(8'h00, 8'h80, 1);
    in_valid = 0;
    drain("drain signed");

    // Back-to-back stream, mixed modes
    max_run = 0;
    for (int k = 0; k < 20; k++) send(8'($urandom), 8'($urandom), 1'($urandom));
    in_valid = 0;
    drain("drain stream");
    check("stream consecutive outputs", max_run, 20);

    // Back-pressure for 5 cycles while traffic keeps arriving
    fork
      begin
        for (int k = 0; k < 8; k++) send(8'($urandom), 8'($urandom), 1'($urandom));
        in_valid = 0;
      end
      begin
        int w = 0;
        while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
        check("backpressure saw output", out_valid, 1);
        out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain("drain backpressure");

    // Reset with three in flight: none may emerge
    out_ready = 0;
    send(8'h12, 8'h34, 0);
    send(8'h56, 8'h78, 1);
    send(8'h9A, 8'hBC, 0);
    in_valid = 0;
    check("full pipe out_valid", out_valid, 1);
    reset = 1;
    q.delete();
    #1 check("in_ready during reset", in_ready, 0);
    @(posedge clk); #1 reset = 0;
    check("post-reset out_valid", out_valid, 0);
    out_ready = 1;
    c = 0;
    repeat (6) begin @(posedge clk); #1; if (out_valid) c++; end
    check("flushed outputs", c, 0);
    latency_test(8'hC3, 8'h5A, 1, "latency after reset");
    drain("drain after reset");

    c = 0;
    while (!(g_sub[0].done && g_sub[1].done) && c < 20000) begin @(posedge clk); c++; end
    check("w4 done", g_sub[0].done, 1);
    check("w16 done", g_sub[1].done, 1);
    check("w4 queue empty", g_sub[0].sq.size(), 0);
    check("w16 queue empty", g_sub[1].sq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
